axis_frame_len_stats: RTL and testbench

Downstream consumer of the frame-length monitor. It accepts one frame_len/frame_len_valid pulse per completed AXI-Stream frame and accumulates per-port statistics:
- frame count
- byte count
- min and max length
- runt count
- oversize count

A snapshot request captures all statistics atomically into an output holding register, with optional clear-on-read. Software or the MAC stats collector drains the snapshot through a valid/ready handshake.

---
 rtl/axis_frame_len_stats_pkg.sv | 30 +++
 rtl/axis_frame_len_stats_counter.sv | 51 +++++
 rtl/axis_frame_len_stats.sv | 138 +++++++++++++
 tb/tb_axis_frame_len_stats.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_len_stats_pkg.sv
// Shared types and constants for the frame-length statistics block.
// Optional build macro: AXIS_FRAME_LEN_STATS_SATURATE_EN (see stats_counter).
package axis_frame_len_stats_pkg;

    // Field widths of the default configuration, used by the snapshot record.
    localparam int SNAP_LEN_W   = 16;
    localparam int SNAP_COUNT_W = 32;
    localparam int SNAP_BYTE_W  = 48;

    // Internal running minimum starts at all-ones so the first frame always wins.
    // Wide enough for any sane LEN_WIDTH; users slice the low bits they need.
    localparam logic [63:0] MIN_RESET = '1;

    // Snapshot FSM: IDLE accepts a request, HOLD presents the captured record.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } snap_state_t;

    // One captured statistics record (default widths).
    typedef struct packed {
        logic [SNAP_COUNT_W-1:0] frame_count;
        logic [SNAP_BYTE_W-1:0]  byte_count;
        logic [SNAP_LEN_W-1:0]   min_len;
        logic [SNAP_LEN_W-1:0]   max_len;
        logic [SNAP_COUNT_W-1:0] runt_count;
        logic [SNAP_COUNT_W-1:0] oversize_count;
    } stats_snap_t;

endpackage

// File: rtl/axis_frame_len_stats_counter.sv
// Accumulating counter: count += add_val when inc, synchronous clear.
// Wraps modulo 2^WIDTH by default; with AXIS_FRAME_LEN_STATS_SATURATE_EN
// defined it sticks at all-ones until cleared.
// count_next is the value the register takes if no clear is applied, so the
// parent can capture a snapshot that already includes this cycle's update.
module stats_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] add_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

`ifdef AXIS_FRAME_LEN_STATS_SATURATE_EN
    logic [WIDTH:0] sum;

    // Saturating add: an overflow carry pins the counter at all-ones.
    always_comb begin
        sum        = {1'b0, count} + {1'b0, add_val};
        count_next = count;
        if (inc) begin
            count_next = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end
`else
    logic [WIDTH-1:0] sum;

    // Wrapping add: the carry out is simply dropped.
    always_comb begin
        sum        = count + add_val;
        count_next = count;
        if (inc) begin
            count_next = sum;
        end
    end
`endif

    // Counter register; clear wins over the pending update.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/axis_frame_len_stats.sv
// Per-port frame-length statistics with an atomic snapshot register.
// Handshake: stat_* is offered while stat_valid=1 and is consumed on a cycle
// where stat_valid && stat_ready; snap_req is taken only while
// snap_req_ready=1 (i.e. no snapshot is outstanding) and is never queued.
// Optional build macro: AXIS_FRAME_LEN_STATS_SATURATE_EN (saturating counters).
module axis_frame_len_stats
    import axis_frame_len_stats_pkg::*;
#(
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 32,
    parameter int BYTE_WIDTH  = 48,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1518
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LEN_WIDTH-1:0]   frame_len,
    input  logic                   frame_len_valid,
    input  logic                   snap_req,
    input  logic                   snap_clear,
    output logic                   snap_req_ready,
    output logic                   stat_valid,
    input  logic                   stat_ready,
    output logic [COUNT_WIDTH-1:0] stat_frame_count,
    output logic [BYTE_WIDTH-1:0]  stat_byte_count,
    output logic [LEN_WIDTH-1:0]   stat_min_len,
    output logic [LEN_WIDTH-1:0]   stat_max_len,
    output logic [COUNT_WIDTH-1:0] stat_runt_count,
    output logic [COUNT_WIDTH-1:0] stat_oversize_count
);

    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

    snap_state_t state, state_next;
    logic        capture;
    logic        clr_acc;

    logic [COUNT_WIDTH-1:0] frame_cnt, frame_nxt;
    logic [BYTE_WIDTH-1:0]  byte_cnt, byte_nxt;
    logic [COUNT_WIDTH-1:0] runt_cnt, runt_nxt;
    logic [COUNT_WIDTH-1:0] over_cnt, over_nxt;
    logic [LEN_WIDTH-1:0]   min_r, min_nxt;
    logic [LEN_WIDTH-1:0]   max_r, max_nxt;
    logic                   is_runt, is_over;

    assign is_runt = frame_len_valid && (frame_len < MIN_L);
    assign is_over = frame_len_valid && (frame_len > MAX_L);

    stats_counter #(.WIDTH(COUNT_WIDTH)) u_frame_cnt (
        .clk(clk), .rst(rst), .clr(clr_acc), .inc(frame_len_valid),
        .add_val(COUNT_WIDTH'(1)), .count(frame_cnt), .count_next(frame_nxt)
    );

    stats_counter #(.WIDTH(BYTE_WIDTH)) u_byte_cnt (
        .clk(clk), .rst(rst), .clr(clr_acc), .inc(frame_len_valid),
        .add_val(BYTE_WIDTH'(frame_len)), .count(byte_cnt), .count_next(byte_nxt)
    );

    stats_counter #(.WIDTH(COUNT_WIDTH)) u_runt_cnt (
        .clk(clk), .rst(rst), .clr(clr_acc), .inc(is_runt),
        .add_val(COUNT_WIDTH'(1)), .count(runt_cnt), .count_next(runt_nxt)
    );

    stats_counter #(.WIDTH(COUNT_WIDTH)) u_over_cnt (
        .clk(clk), .rst(rst), .clr(clr_acc), .inc(is_over),
        .add_val(COUNT_WIDTH'(1)), .count(over_cnt), .count_next(over_nxt)
    );

    // Running min/max including the frame arriving this cycle.
    always_comb begin
        min_nxt = min_r;
        max_nxt = max_r;
        if (frame_len_valid) begin
            if (frame_len < min_r) min_nxt = frame_len;
            if (frame_len > max_r) max_nxt = frame_len;
        end
    end

    // Min/max registers; a clearing snapshot restarts the period.
    always_ff @(posedge clk) begin
        if (rst || clr_acc) begin
            min_r <= MIN_RESET[LEN_WIDTH-1:0];
            max_r <= '0;
        end else begin
            min_r <= min_nxt;
            max_r <= max_nxt;
        end
    end

    // Snapshot FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Snapshot FSM next state: request opens HOLD, handshake closes it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (snap_req)   state_next = HOLD;
            HOLD:    if (stat_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Snapshot FSM outputs and capture/clear strobes.
    always_comb begin
        stat_valid     = (state == HOLD);
        snap_req_ready = (state == IDLE);
        capture        = (state == IDLE) && snap_req;
        clr_acc        = capture && snap_clear;
    end

    // Holding register: loads next-state accumulators so a same-cycle frame
    // lands in the captured period; min/max read 0 for an empty period.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frame_count    <= '0;
            stat_byte_count     <= '0;
            stat_min_len        <= '0;
            stat_max_len        <= '0;
            stat_runt_count     <= '0;
            stat_oversize_count <= '0;
        end else if (capture) begin
            stat_frame_count    <= frame_nxt;
            stat_byte_count     <= byte_nxt;
            stat_min_len        <= (frame_nxt == '0) ? '0 : min_nxt;
            stat_max_len        <= (frame_nxt == '0) ? '0 : max_nxt;
            stat_runt_count     <= runt_nxt;
            stat_oversize_count <= over_nxt;
        end
    end

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Self-checking bench for axis_frame_len_stats: constant vector table,
// hand sequences for the multi-cycle corners, randomized traffic against a
// list-based reference model, and a narrow-counter instance for wrap/saturate.
module tb_axis_frame_len_stats;
    import axis_frame_len_stats_pkg::*;

    localparam int SNAP_W = $bits(stats_snap_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (default widths) ----------------
    logic [15:0] frame_len = '0;
    logic        frame_len_valid = 1'b0;
    logic        snap_req = 1'b0;
    logic        snap_clear = 1'b0;
    logic        stat_ready = 1'b0;
    logic        snap_req_ready, stat_valid;
    logic [31:0] stat_frame_count, stat_runt_count, stat_oversize_count;
    logic [47:0] stat_byte_count;
    logic [15:0] stat_min_len, stat_max_len;

    axis_frame_len_stats dut (
        .clk(clk), .rst(rst),
        .frame_len(frame_len), .frame_len_valid(frame_len_valid),
        .snap_req(snap_req), .snap_clear(snap_clear),
        .snap_req_ready(snap_req_ready), .stat_valid(stat_valid),
        .stat_ready(stat_ready),
        .stat_frame_count(stat_frame_count), .stat_byte_count(stat_byte_count),
        .stat_min_len(stat_min_len), .stat_max_len(stat_max_len),
        .stat_runt_count(stat_runt_count), .stat_oversize_count(stat_oversize_count)
    );

    // ---------------- narrow DUT (COUNT_WIDTH=4) ----------------
    logic [15:0] s_len = '0;
    logic        s_fv = 1'b0, s_req = 1'b0, s_clr = 1'b0, s_rdy = 1'b0;
    logic        s_req_ready, s_valid;
    logic [3:0]  s_frame_count, s_runt_count, s_over_count;
    logic [47:0] s_byte_count;
    logic [15:0] s_min_len, s_max_len;

    axis_frame_len_stats #(.COUNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst),
        .frame_len(s_len), .frame_len_valid(s_fv),
        .snap_req(s_req), .snap_clear(s_clr),
        .snap_req_ready(s_req_ready), .stat_valid(s_valid),
        .stat_ready(s_rdy),
        .stat_frame_count(s_frame_count), .stat_byte_count(s_byte_count),
        .stat_min_len(s_min_len), .stat_max_len(s_max_len),
        .stat_runt_count(s_runt_count), .stat_oversize_count(s_over_count)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int period_q[$];              // lengths of frames in the current period
    bit hold_m = 1'b0;            // model: a snapshot is outstanding
    logic [SNAP_W-1:0] exp_q[$];  // expected snapshots awaiting comparison

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Statistics of the current period computed straight from the frame list.
    function automatic stats_snap_t model_snap();
        stats_snap_t s;
        longint sum = 0;
        int mn = 65535, mx = 0, runts = 0, overs = 0;
        foreach (period_q[i]) begin
            sum += period_q[i];
            if (period_q[i] < mn) mn = period_q[i];
            if (period_q[i] > mx) mx = period_q[i];
            if (period_q[i] < 64) runts++;
            if (period_q[i] > 1518) overs++;
        end
        s.frame_count    = 32'(period_q.size());
        s.byte_count     = 48'(sum);
        s.min_len        = (period_q.size() == 0) ? 16'd0 : 16'(mn);
        s.max_len        = (period_q.size() == 0) ? 16'd0 : 16'(mx);
        s.runt_count     = 32'(runts);
        s.oversize_count = 32'(overs);
        return s;
    endfunction

    task automatic check_fields(input string tag, input stats_snap_t e);
        check({tag, ".frame_count"}, 64'(stat_frame_count), 64'(e.frame_count));
        check({tag, ".byte_count"}, 64'(stat_byte_count), 64'(e.byte_count));
        check({tag, ".min_len"}, 64'(stat_min_len), 64'(e.min_len));
        check({tag, ".max_len"}, 64'(stat_max_len), 64'(e.max_len));
        check({tag, ".runt_count"}, 64'(stat_runt_count), 64'(e.runt_count));
        check({tag, ".oversize_count"}, 64'(stat_oversize_count), 64'(e.oversize_count));
    endtask

    // ---------------- driver tasks ----------------
    // One clock of stimulus on the main DUT; the model advances in step and
    // outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic fv, input logic [15:0] len, input logic sr,
                        input logic sc, input logic rdy);
        bit accepted = 1'b0;
        stats_snap_t got_exp;
        frame_len_valid = fv;
        frame_len       = len;
        snap_req        = sr;
        snap_clear      = sc;
        stat_ready      = rdy;
        if (fv) period_q.push_back(int'(len));
        if (!hold_m) begin
            if (sr) begin
                accepted = 1'b1;
                exp_q.push_back(model_snap());
                if (sc) period_q.delete();
                hold_m = 1'b1;
            end
        end else if (rdy) begin
            hold_m = 1'b0;
        end
        @(posedge clk);
        #1;
        check("stat_valid", 64'(stat_valid), 64'(hold_m));
        check("snap_req_ready", 64'(snap_req_ready), 64'(!hold_m));
        if (accepted && exp_q.size() > 0) begin
            got_exp = stats_snap_t'(exp_q.pop_front());
            check_fields("model", got_exp);
        end
    endtask

    task automatic idle_inputs();
        frame_len_valid = 1'b0; frame_len = '0; snap_req = 1'b0;
        snap_clear = 1'b0; stat_ready = 1'b0;
        s_fv = 1'b0; s_len = '0; s_req = 1'b0; s_clr = 1'b0; s_rdy = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold_m = 1'b0;
        period_q.delete();
        exp_q.delete();
        check("reset.stat_valid", 64'(stat_valid), 64'd0);
        check("reset.snap_req_ready", 64'(snap_req_ready), 64'd1);
        check_fields("reset", '0);
        check("reset.small_valid", 64'(s_valid), 64'd0);
    endtask

    task automatic s_step(input logic fv, input logic [15:0] len, input logic sr,
                          input logic sc, input logic rdy);
        s_fv = fv; s_len = len; s_req = sr; s_clr = sc; s_rdy = rdy;
        @(posedge clk);
        #1;
    endtask

    // ---------------- constant vector table ----------------
    typedef struct {
        int          n;
        int          lens[4];
        stats_snap_t exp;
    } vec_t;

    vec_t vecs[5];
    stats_snap_t held;
    int bnd[4];

    initial begin
        vecs[0].n = 4; vecs[0].lens = '{64, 1518, 60, 1600};
        vecs[0].exp = '{frame_count: 4, byte_count: 3242, min_len: 60, max_len: 1600,
                        runt_count: 1, oversize_count: 1};
        vecs[1].n = 0; vecs[1].lens = '{0, 0, 0, 0};
        vecs[1].exp = '0;
        vecs[2].n = 1; vecs[2].lens = '{0, 0, 0, 0};
        vecs[2].exp = '{frame_count: 1, byte_count: 0, min_len: 0, max_len: 0,
                        runt_count: 1, oversize_count: 0};
        vecs[3].n = 4; vecs[3].lens = '{63, 64, 1518, 1519};
        vecs[3].exp = '{frame_count: 4, byte_count: 3164, min_len: 63, max_len: 1519,
                        runt_count: 1, oversize_count: 1};
        vecs[4].n = 1; vecs[4].lens = '{65535, 0, 0, 0};
        vecs[4].exp = '{frame_count: 1, byte_count: 65535, min_len: 65535, max_len: 65535,
                        runt_count: 0, oversize_count: 1};
        bnd = '{63, 64, 1518, 1519};

        do_reset();

        // Table: frames, clearing snapshot, compare constants, handshake.
        for (int v = 0; v < 5; v++) begin
            for (int f = 0; f < vecs[v].n; f++) step(1'b1, 16'(vecs[v].lens[f]), 1'b0, 1'b0, 1'b0);
            step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
            check_fields($sformatf("vec%0d", v), vecs[v].exp);
            step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        end

        // Same-cycle frame with a clearing snapshot belongs to the old period.
        step(1'b1, 16'd100, 1'b1, 1'b1, 1'b0);
        check_fields("same_cycle", '{frame_count: 1, byte_count: 100, min_len: 100,
                                     max_len: 100, runt_count: 0, oversize_count: 0});
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        check_fields("after_clear", '{frame_count: 1, byte_count: 200, min_len: 200,
                                      max_len: 200, runt_count: 0, oversize_count: 0});
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

        // Long HOLD: outputs frozen, requests ignored, frames still counted.
        step(1'b1, 16'd100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'd200, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        held = '{frame_count: 2, byte_count: 300, min_len: 100, max_len: 200,
                 runt_count: 0, oversize_count: 0};
        for (int c = 0; c < 10; c++) begin
            step(c == 1 || c == 4 || c == 7,
                 (c == 1) ? 16'd50 : (c == 4) ? 16'd1600 : 16'd70,
                 c == 2 || c == 5 || c == 8, 1'b1, 1'b0);
            check_fields($sformatf("hold%0d", c), held);
        end
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        check_fields("post_hold", '{frame_count: 5, byte_count: 2020, min_len: 50,
                                    max_len: 1600, runt_count: 1, oversize_count: 1});
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

        // Reset during HOLD drops the snapshot and the accumulators.
        step(1'b1, 16'd300, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'd400, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        check_fields("post_reset", '0);
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

        // Narrow counters: 17 runt frames into a 4-bit frame counter.
        for (int f = 0; f < 17; f++) s_step(1'b1, 16'd10, 1'b0, 1'b0, 1'b0);
        s_step(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        check("small.valid", 64'(s_valid), 64'd1);
`ifdef AXIS_FRAME_LEN_STATS_SATURATE_EN
        check("small.frame_count", 64'(s_frame_count), 64'd15);
        check("small.runt_count", 64'(s_runt_count), 64'd15);
`else
        check("small.frame_count", 64'(s_frame_count), 64'd1);
        check("small.runt_count", 64'(s_runt_count), 64'd1);
`endif
        check("small.byte_count", 64'(s_byte_count), 64'd170);
        check("small.min_len", 64'(s_min_len), 64'd10);
        check("small.max_len", 64'(s_max_len), 64'd10);
        check("small.oversize_count", 64'(s_over_count), 64'd0);
        s_step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        check("small.release", 64'(s_valid), 64'd0);

        // Randomized traffic against the list model.
        for (int c = 0; c < 800; c++) begin
            int bucket = $urandom_range(0, 3);
            int len;
            case (bucket)
                0:       len = $urandom_range(0, 63);
                1:       len = $urandom_range(64, 1518);
                2:       len = $urandom_range(1519, 65535);
                default: len = bnd[$urandom_range(0, 3)];
            endcase
            step(1'($urandom_range(0, 1)), 16'(len), ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
